pwm_capture: RTL and testbench

Servo/RC PWM decoder: measures the high time of an incoming 50 Hz PWM pulse and converts it back to a position code of 0..180. It uses the same timing law as the servo PWM generator, width = MIN_CYCLES + STEP_CYCLES × position. It sits between the RC receiver input pin and the stabilization control logic. It reports a one-cycle valid strobe per decoded pulse, a sticky loss-of-signal flag, and an out-of-range error strobe.

---
 rtl/pwm_capture.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Servo/RC PWM decoder: measures pulse high time and converts it to a 0..MAX_POS position code.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned MIN_CYCLES     = 50000,
    parameter int unsigned STEP_CYCLES    = 288,
    parameter int unsigned MAX_POS        = 180,
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter int unsigned FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] position,
    output logic       pos_valid,
    output logic       signal_lost,
    output logic       width_err
);

    localparam int unsigned LO_CYCLES  = MIN_CYCLES - 8 * STEP_CYCLES;
    localparam int unsigned HI_CYCLES  = MIN_CYCLES + (MAX_POS + 8) * STEP_CYCLES;
    localparam int unsigned TOP_CYCLES = MIN_CYCLES + MAX_POS * STEP_CYCLES;

    localparam logic [19:0] LO_W     = 20'(LO_CYCLES);
    localparam logic [19:0] HI_W     = 20'(HI_CYCLES);
    localparam logic [19:0] MIN_W    = 20'(MIN_CYCLES);
    localparam logic [19:0] TOP_W    = 20'(TOP_CYCLES);
    localparam logic [19:0] HALF_W   = 20'(STEP_CYCLES / 2);
    localparam logic [23:0] DIV_INIT = 24'(STEP_CYCLES) << 7;
    localparam logic [20:0] TO_W     = 21'(TIMEOUT_CYCLES);

    if (FILTER_CYCLES == 0 || MAX_POS > 255 || STEP_CYCLES == 0 ||
        MIN_CYCLES <= 8 * STEP_CYCLES + 8 || HI_CYCLES >= (1 << 20) ||
        (TOP_CYCLES - MIN_CYCLES + STEP_CYCLES / 2) >= (1 << 16) ||
        TIMEOUT_CYCLES >= (1 << 21)) begin : g_param_check
        $error("pwm_capture: unsupported parameter set");
    end

    // Synchronizer is deliberately not reset so s_in reflects the true pin level right after reset.
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        sync1_q <= pwm_in;
        sync2_q <= sync1_q;
    end

    logic s_in;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);

    logic           s_filt_q;
    logic           s_filt_d;
    logic [FCW-1:0] flt_cnt_q;
    logic [FCW-1:0] flt_cnt_d;

    always_comb begin
        s_filt_d  = s_filt_q;
        flt_cnt_d = '0;
        if (sync2_q != s_filt_q) begin
            if (flt_cnt_q == FCW'(FILTER_CYCLES - 1)) begin
                s_filt_d = sync2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_filt_q  <= sync2_q;
            flt_cnt_q <= '0;
        end else begin
            s_filt_q  <= s_filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign s_in = s_filt_q;
`else
    assign s_in = sync2_q;
`endif

    logic s_prev_q;
    logic rise;
    logic fall;

    assign rise = s_in & ~s_prev_q;
    assign fall = ~s_in & s_prev_q;

    typedef enum logic [1:0] {
        M_ARM,
        M_WAIT_RISE,
        M_MEASURE
    } meas_state_t;

    typedef enum logic {
        D_IDLE,
        D_RUN
    } div_state_t;

    meas_state_t meas_q;
    meas_state_t meas_d;
    logic [19:0] high_cnt_q;
    logic [19:0] high_cnt_d;
    logic        width_err_q;
    logic        width_err_d;
    logic        start_div;
    logic [19:0] wc;
    logic [15:0] numer;

    always_comb begin
        meas_d      = meas_q;
        high_cnt_d  = high_cnt_q;
        width_err_d = 1'b0;
        start_div   = 1'b0;

        if (high_cnt_q < MIN_W) begin
            wc = MIN_W;
        end else if (high_cnt_q > TOP_W) begin
            wc = TOP_W;
        end else begin
            wc = high_cnt_q;
        end
        numer = 16'(wc - MIN_W + HALF_W);

        case (meas_q)
            M_ARM: begin
                if (!s_in) begin
                    meas_d = M_WAIT_RISE;
                end
            end
            M_WAIT_RISE: begin
                if (rise) begin
                    high_cnt_d = 20'd1;
                    meas_d     = M_MEASURE;
                end
            end
            M_MEASURE: begin
                if (fall) begin
                    meas_d = M_WAIT_RISE;
                    if (high_cnt_q < LO_W || high_cnt_q > HI_W) begin
                        width_err_d = 1'b1;
                    end else begin
                        start_div = 1'b1;
                    end
                end else if (high_cnt_q != '1) begin
                    high_cnt_d = high_cnt_q + 20'd1;
                end
            end
            default: meas_d = M_ARM;
        endcase
    end

    div_state_t  div_q;
    div_state_t  div_d;
    logic [23:0] rem_q;
    logic [23:0] rem_d;
    logic [23:0] dvs_q;
    logic [23:0] dvs_d;
    logic [7:0]  quo_q;
    logic [7:0]  quo_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  position_q;
    logic [7:0]  position_d;
    logic        pos_valid_q;
    logic        pos_valid_d;

    // Quotient is known to fit 8 bits, so the divisor starts pre-shifted by 7 and walks right.
    always_comb begin
        div_d       = div_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        bit_d       = bit_q;
        position_d  = position_q;
        pos_valid_d = 1'b0;

        case (div_q)
            D_IDLE: begin
                if (start_div) begin
                    rem_d = {8'd0, numer};
                    dvs_d = DIV_INIT;
                    quo_d = '0;
                    bit_d = '0;
                    div_d = D_RUN;
                end
            end
            D_RUN: begin
                if (rem_q >= dvs_q) begin
                    rem_d = rem_q - dvs_q;
                    quo_d = {quo_q[6:0], 1'b1};
                end else begin
                    quo_d = {quo_q[6:0], 1'b0};
                end
                dvs_d = dvs_q >> 1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    position_d  = quo_d;
                    pos_valid_d = 1'b1;
                    div_d       = D_IDLE;
                end
            end
            default: div_d = D_IDLE;
        endcase
    end

    logic [20:0] to_q;
    logic [20:0] to_d;
    logic        lost_q;
    logic        lost_d;

    // A decode in the same cycle as the timeout hit takes precedence.
    always_comb begin
        if (meas_q == M_WAIT_RISE && rise) begin
            to_d = '0;
        end else if (to_q == '1) begin
            to_d = to_q;
        end else begin
            to_d = to_q + 21'd1;
        end

        lost_d = lost_q;
        if (pos_valid_d) begin
            lost_d = 1'b0;
        end else if (to_d == TO_W) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev_q    <= 1'b0;
            meas_q      <= M_ARM;
            high_cnt_q  <= '0;
            width_err_q <= 1'b0;
            div_q       <= D_IDLE;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            bit_q       <= '0;
            position_q  <= '0;
            pos_valid_q <= 1'b0;
            to_q        <= '0;
            lost_q      <= 1'b1;
        end else begin
            s_prev_q    <= s_in;
            meas_q      <= meas_d;
            high_cnt_q  <= high_cnt_d;
            width_err_q <= width_err_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            bit_q       <= bit_d;
            position_q  <= position_d;
            pos_valid_q <= pos_valid_d;
            to_q        <= to_d;
            lost_q      <= lost_d;
        end
    end

    assign position    = position_q;
    assign pos_valid   = pos_valid_q;
    assign signal_lost = lost_q;
    assign width_err   = width_err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with scaled-down timing parameters.
module tb_pwm_capture;

    localparam int MIN  = 300;
    localparam int STEP = 8;
    localparam int MAXP = 180;
    localparam int TO   = 4000;
    localparam int FILT = 4;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FD = FILT;
`else
    localparam int FD = 0;
`endif
    localparam int LAT_ERR = 3 + FD;
    localparam int LAT_VAL = 11 + FD;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [7:0] position;
    logic       pos_valid;
    logic       signal_lost;
    logic       width_err;

    int checks = 0;
    int errors = 0;
    int last_pos;
    bit exp_sl;

    pwm_capture #(
        .MIN_CYCLES    (MIN),
        .STEP_CYCLES   (STEP),
        .MAX_POS       (MAXP),
        .TIMEOUT_CYCLES(TO),
        .FILTER_CYCLES (FILT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .position   (position),
        .pos_valid  (pos_valid),
        .signal_lost(signal_lost),
        .width_err  (width_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode of one high time: -1 means rejected, else rounded position.
    function automatic int model(input int h);
        int lo;
        int hi;
        int wc;
        lo = MIN - 8 * STEP;
        hi = MIN + (MAXP + 8) * STEP;
        if (h < lo || h > hi) return -1;
        wc = (h < MIN) ? MIN : ((h > MIN + MAXP * STEP) ? MIN + MAXP * STEP : h);
        return (wc - MIN + STEP / 2) / STEP;
    endfunction

    task automatic run_pulse(input int h, input int l, input string name);
        int exp;
        int n_pv;
        int n_we;
        int k_pv;
        int k_we;
        int pv_pos;
        bit sl_at_pv;
        bit bad_high;
        exp = model(h);
        n_pv = 0; n_we = 0; k_pv = -1; k_we = -1; pv_pos = -1; sl_at_pv = 1'b1; bad_high = 1'b0;
        pwm_in = 1'b1;
        for (int k = 0; k < h; k++) begin
            step();
            if (pos_valid !== 1'b0 || width_err !== 1'b0) bad_high = 1'b1;
        end
        checks++;
        if (bad_high) begin
            errors++;
            $display("FAIL %s quiet_high: strobe seen during high phase, required none", name);
        end
        pwm_in = 1'b0;
        for (int k = 1; k <= l; k++) begin
            step();
            if (pos_valid === 1'b1) begin
                n_pv++; k_pv = k; pv_pos = int'(position); sl_at_pv = signal_lost;
            end
            if (width_err === 1'b1) begin
                n_we++; k_we = k;
            end
        end
        if (exp < 0) begin
            checks++;
            if (n_we !== 1 || k_we !== LAT_ERR) begin
                errors++;
                $display("FAIL %s width_err: count=%0d at=%0d, required 1 at %0d", name, n_we, k_we, LAT_ERR);
            end
            checks++;
            if (n_pv !== 0) begin
                errors++;
                $display("FAIL %s no_pos_valid: count=%0d, required 0", name, n_pv);
            end
            checks++;
            if (int'(position) !== last_pos) begin
                errors++;
                $display("FAIL %s position_held: got %0d, required %0d", name, position, last_pos);
            end
        end else begin
            checks++;
            if (n_pv !== 1 || k_pv !== LAT_VAL) begin
                errors++;
                $display("FAIL %s pos_valid: count=%0d at=%0d, required 1 at %0d", name, n_pv, k_pv, LAT_VAL);
            end
            checks++;
            if (n_we !== 0) begin
                errors++;
                $display("FAIL %s no_width_err: count=%0d, required 0", name, n_we);
            end
            checks++;
            if (pv_pos !== exp) begin
                errors++;
                $display("FAIL %s position: got %0d (h=%0d), required %0d", name, pv_pos, h, exp);
            end
            checks++;
            if (sl_at_pv !== 1'b0) begin
                errors++;
                $display("FAIL %s lost_at_valid: got %b, required 0", name, sl_at_pv);
            end
            last_pos = exp;
            exp_sl = 1'b0;
        end
        checks++;
        if (signal_lost !== exp_sl) begin
            errors++;
            $display("FAIL %s signal_lost: got %b, required %b", name, signal_lost, exp_sl);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (position !== 8'd0 || pos_valid !== 1'b0 || width_err !== 1'b0 || signal_lost !== 1'b1) begin
            errors++;
            $display("FAIL %s reset_outputs: pos=%0d pv=%b we=%b sl=%b, required 0 0 0 1",
                     name, position, pos_valid, width_err, signal_lost);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (4) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        last_pos = 0;
        exp_sl = 1'b1;
        checks++;
        if (signal_lost !== 1'b1) begin
            errors++;
            $display("FAIL reset_release signal_lost: got %b, required 1", signal_lost);
        end
    endtask

    task automatic test_basic();
        run_pulse(MIN, 40, "min_pulse_a");
        run_pulse(MIN, 40, "min_pulse_b");
    endtask

    task automatic test_rounding();
        run_pulse(1020, 30, "round_90");
        run_pulse(1023, 30, "round_90_hi");
        run_pulse(1024, 30, "round_91");
    endtask

    task automatic test_window();
        run_pulse(1740, 30, "max_180");
        run_pulse(1800, 30, "clamp_hi");
        run_pulse(250, 30, "clamp_lo");
        run_pulse(1020, 30, "set_90");
        run_pulse(200, 30, "too_short");
        run_pulse(236, 30, "lo_edge_in");
        run_pulse(235, 30, "lo_edge_out");
        run_pulse(1804, 30, "hi_edge_in");
        run_pulse(1805, 30, "hi_edge_out");
    endtask

    task automatic test_timeout();
        int n_pv;
        n_pv = 0;
        pwm_in = 1'b1;
        for (int k = 1; k <= TO + 6; k++) begin
            step();
            if (k == 660) pwm_in = 1'b0;
            if (pos_valid === 1'b1) n_pv++;
            if (k == TO + 2 + FD) begin
                checks++;
                if (signal_lost !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_before: signal_lost=%b at k=%0d, required 0", signal_lost, k);
                end
            end
            if (k == TO + 3 + FD) begin
                checks++;
                if (signal_lost !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_at: signal_lost=%b at k=%0d, required 1", signal_lost, k);
                end
            end
        end
        checks++;
        if (n_pv !== 1 || position !== 8'd45) begin
            errors++;
            $display("FAIL timeout_pulse: pv_count=%0d pos=%0d, required 1 and 45", n_pv, position);
        end
        last_pos = 45;
        exp_sl = 1'b1;
        run_pulse(1020, 40, "recover_after_timeout");
    endtask

    task automatic test_stuck_high();
        exp_sl = 1'b1;
        run_pulse(TO + 100, 30, "stuck_high");
    endtask

    task automatic test_arm_reset();
        int n_strobe;
        n_strobe = 0;
        pwm_in = 1'b1;
        repeat (50) step();
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset_mid_pulse");
        rst = 1'b0;
        repeat (100) step();
        pwm_in = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (pos_valid === 1'b1 || width_err === 1'b1) n_strobe++;
        end
        checks++;
        if (n_strobe !== 0) begin
            errors++;
            $display("FAIL arm_discard: strobes=%0d, required 0", n_strobe);
        end
        last_pos = 0;
        exp_sl = 1'b1;
        run_pulse(660, 40, "after_arm_45");
    endtask

    task automatic test_reset_mid_div();
        int n_strobe;
        n_strobe = 0;
        pwm_in = 1'b1;
        repeat (1020) step();
        pwm_in = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pos_valid === 1'b1 || width_err === 1'b1) n_strobe++;
        end
        checks++;
        if (n_strobe !== 0 || position !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_div: strobes=%0d pos=%0d, required 0 and 0", n_strobe, position);
        end
        last_pos = 0;
        exp_sl = 1'b1;
        run_pulse(1024, 30, "after_div_abort");
    endtask

    task automatic test_glitch();
        int n_pv;
        int n_we;
        int pv_pos;
        int exp_pos;
        int exp_we;
        n_pv = 0; n_we = 0; pv_pos = -1;
`ifdef PWM_CAP_GLITCH_FILTER_EN
        exp_pos = model(1020);
        exp_we = 0;
`else
        exp_pos = model(918);
        exp_we = (model(100) < 0) ? 1 : 0;
`endif
        for (int k = 0; k < 1060; k++) begin
            pwm_in = (k < 100) ? 1'b1 : ((k < 102) ? 1'b0 : ((k < 1020) ? 1'b1 : 1'b0));
            step();
            if (pos_valid === 1'b1) begin
                n_pv++; pv_pos = int'(position);
            end
            if (width_err === 1'b1) n_we++;
        end
        checks++;
        if (n_we !== exp_we) begin
            errors++;
            $display("FAIL glitch_width_err: count=%0d, required %0d", n_we, exp_we);
        end
        checks++;
        if (n_pv !== 1 || pv_pos !== exp_pos) begin
            errors++;
            $display("FAIL glitch_position: pv_count=%0d pos=%0d, required 1 and %0d", n_pv, pv_pos, exp_pos);
        end
        last_pos = exp_pos;
        exp_sl = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) begin
            run_pulse(int'($urandom_range(1900, 200)), int'($urandom_range(300, 20)), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        last_pos = 0;
        exp_sl = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_window();
        test_timeout();
        test_stuck_high();
        test_arm_reset();
        test_reset_mid_div();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
